// File: rtl/regfile_dbg.sv
// Debug port for a 32 x 32-bit register file: dumps a range of registers out as a stream,
// or loads a range from an input stream through the register file's write port.
//
// state  | meaning
// IDLE   | waiting for a command, cmd_ready high
// RD_CAP | register-file read data valid this edge; capture it into the output word
// RD_OUT | output word presented, waiting for out_ready
// LOAD   | accepting load words, one write per ld handshake
// DONE   | one-cycle completion pulse
module regfile_dbg (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid_i,
   output logic        cmd_ready_o,
   input  logic        cmd_op_i,
   input  logic [4:0]  cmd_first_i,
   input  logic [5:0]  cmd_count_i,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic [31:0] out_data_o,
   output logic [4:0]  out_idx_o,
   input  logic        ld_valid_i,
   output logic        ld_ready_o,
   input  logic [31:0] ld_data_i,
   output logic [4:0]  rf_raddr_o,
   input  logic [31:0] rf_rdata_i,
   output logic        rf_wE_o,
   output logic [4:0]  rf_wR_o,
   output logic [31:0] rf_wD_o,
   output logic        busy_o,
   output logic        done_o
);

   typedef enum logic [2:0] {
      S_IDLE, S_RD_CAP, S_RD_OUT, S_LOAD, S_DONE
   } state_t;

   state_t      state_q;
   logic        cmd_ready_q;
   logic        out_valid_q;
   logic [31:0] out_data_q;
   logic [4:0]  out_idx_q;
   logic        ld_ready_q;
   logic [4:0]  rf_raddr_q;
   logic        rf_we_q;
   logic [4:0]  rf_wr_q;
   logic [31:0] rf_wd_q;
   logic        busy_q;
   logic        done_q;
   logic [4:0]  idx_q;
   logic [5:0]  rem_q;
   logic [5:0]  rem_init;

   // The file only has 32 entries, so larger counts saturate.
   assign rem_init = (cmd_count_i > 6'd32) ? 6'd32 : cmd_count_i;

   // The operation is held by the state itself: dumps stay in RD_*, loads in LOAD.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cmd_ready_q <= 1'b1;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_idx_q   <= '0;
         ld_ready_q  <= 1'b0;
         rf_raddr_q  <= '0;
         rf_we_q     <= 1'b0;
         rf_wr_q     <= '0;
         rf_wd_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         idx_q       <= '0;
         rem_q       <= '0;
      end else begin
         rf_we_q <= 1'b0;
         done_q  <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (cmd_valid_i && cmd_ready_q) begin
                  idx_q       <= cmd_first_i;
                  rf_raddr_q  <= cmd_first_i;
                  rem_q       <= rem_init;
                  busy_q      <= 1'b1;
                  cmd_ready_q <= 1'b0;
                  if (cmd_count_i == 6'd0) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end else if (cmd_op_i) begin
                     state_q    <= S_LOAD;
                     ld_ready_q <= 1'b1;
                  end else begin
                     state_q <= S_RD_CAP;
                  end
               end
            end
            S_RD_CAP: begin
               out_data_q  <= rf_rdata_i;
               out_idx_q   <= idx_q;
               out_valid_q <= 1'b1;
               state_q     <= S_RD_OUT;
            end
            S_RD_OUT: begin
               if (out_ready_i) begin
                  out_valid_q <= 1'b0;
                  idx_q       <= idx_q + 5'd1;
                  rf_raddr_q  <= idx_q + 5'd1;
                  rem_q       <= rem_q - 6'd1;
                  if (rem_q == 6'd1) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= S_RD_CAP;
                  end
               end
            end
            S_LOAD: begin
               if (ld_valid_i) begin
                  // Register 0 is hardwired to zero: consume the word, suppress the write.
                  rf_we_q <= (idx_q != 5'd0);
                  rf_wr_q <= idx_q;
                  rf_wd_q <= ld_data_i;
                  idx_q   <= idx_q + 5'd1;
                  rem_q   <= rem_q - 6'd1;
                  if (rem_q == 6'd1) begin
                     state_q    <= S_DONE;
                     done_q     <= 1'b1;
                     ld_ready_q <= 1'b0;
                  end
               end
            end
            S_DONE: begin
               state_q     <= S_IDLE;
               busy_q      <= 1'b0;
               cmd_ready_q <= 1'b1;
            end
            default: begin
               state_q     <= S_IDLE;
               busy_q      <= 1'b0;
               cmd_ready_q <= 1'b1;
               out_valid_q <= 1'b0;
               ld_ready_q  <= 1'b0;
            end
         endcase
      end
   end

   assign cmd_ready_o = cmd_ready_q;
   assign out_valid_o = out_valid_q;
   assign out_data_o  = out_data_q;
   assign out_idx_o   = out_idx_q;
   assign ld_ready_o  = ld_ready_q;
   assign rf_raddr_o  = rf_raddr_q;
   assign rf_wE_o     = rf_we_q;
   assign rf_wR_o     = rf_wr_q;
   assign rf_wD_o     = rf_wd_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;

endmodule

// File: tb/tb_regfile_dbg.sv
// Bench for regfile_dbg: an external register-file model plus a reference array of
// expected contents; every command is driven and checked cycle by cycle.
module tb_regfile_dbg;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid, cmd_ready, cmd_op;
   logic [4:0]  cmd_first;
   logic [5:0]  cmd_count;
   logic        out_valid, out_ready;
   logic [31:0] out_data;
   logic [4:0]  out_idx;
   logic        ld_valid, ld_ready;
   logic [31:0] ld_data;
   logic [4:0]  rf_raddr;
   logic [31:0] rf_rdata;
   logic        rf_we;
   logic [4:0]  rf_wr;
   logic [31:0] rf_wd;
   logic        busy, done;

   int n_vec = 0;
   int n_err = 0;
   int ld_pct = 100;
   logic [31:0] rf_mem  [32] = '{default: 32'h0};
   logic [31:0] ref_mem [32] = '{default: 32'h0};
   logic [31:0] ld_words [$];

   always #5 clk = ~clk;

   // External register file: address sampled on the falling edge, write on the rising edge.
   always @(negedge clk) rf_rdata <= rf_mem[rf_raddr];
   always @(posedge clk) if (rf_we) rf_mem[rf_wr] <= rf_wd;

   regfile_dbg dut (
      .clk(clk), .rst(rst),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
      .cmd_first_i(cmd_first), .cmd_count_i(cmd_count),
      .out_valid_o(out_valid), .out_ready_i(out_ready),
      .out_data_o(out_data), .out_idx_o(out_idx),
      .ld_valid_i(ld_valid), .ld_ready_o(ld_ready), .ld_data_i(ld_data),
      .rf_raddr_o(rf_raddr), .rf_rdata_i(rf_rdata),
      .rf_wE_o(rf_we), .rf_wR_o(rf_wr), .rf_wD_o(rf_wd),
      .busy_o(busy), .done_o(done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Commands offered while the block is busy must be ignored.
   task automatic noise();
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_op    = 1'($urandom_range(0, 1));
      cmd_first = 5'($urandom());
      cmd_count = 6'($urandom());
   endtask

   task automatic finish_cmd();
      noise();
      tick();
      chk("end_done", 32'(done), 32'd0);
      chk("end_busy", 32'(busy), 32'd0);
      chk("end_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("end_we", 32'(rf_we), 32'd0);
      chk("end_ld_ready", 32'(ld_ready), 32'd0);
      chk("end_out_valid", 32'(out_valid), 32'd0);
      cmd_valid = 1'b0;
   endtask

   task automatic run_load(input logic [4:0] first, input int count);
      int n, k;
      logic [4:0] idx;
      logic [31:0] w;
      logic xfer;
      n = (count > 32) ? 32 : count;
      chk("ld_cmd_ready", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1; cmd_op = 1'b1; cmd_first = first; cmd_count = 6'(count);
      ld_valid = 1'b1; ld_data = $urandom();
      tick();
      chk("ld_acc_busy", 32'(busy), 32'd1);
      chk("ld_acc_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("ld_acc_we", 32'(rf_we), 32'd0);
      chk("ld_acc_done", 32'(done), 32'(n == 0));
      if (n == 0) begin
         ld_valid = 1'b0;
         chk("ld_zero_ready", 32'(ld_ready), 32'd0);
         finish_cmd();
         return;
      end
      idx = first;
      k = 0;
      while (k < n) begin
         chk("ld_ready", 32'(ld_ready), 32'd1);
         noise();
         xfer = ($urandom_range(0, 99) < ld_pct);
         if (xfer) begin
            if (ld_words.size() > 0) w = ld_words.pop_front();
            else w = $urandom();
            ld_data = w;
         end else begin
            ld_data = $urandom();
         end
         ld_valid = xfer;
         tick();
         if (xfer) begin
            chk("ld_we", 32'(rf_we), 32'(idx != 5'd0));
            if (idx != 5'd0) begin
               chk("ld_wr", 32'(rf_wr), 32'(idx));
               chk("ld_wd", rf_wd, w);
               ref_mem[idx] = w;
            end
            chk("ld_done", 32'(done), 32'(k == n - 1));
            k++;
            idx = idx + 5'd1;
         end else begin
            chk("ld_idle_we", 32'(rf_we), 32'd0);
            chk("ld_idle_done", 32'(done), 32'd0);
         end
      end
      ld_valid = 1'b0;
      chk("ld_ready_drop", 32'(ld_ready), 32'd0);
      finish_cmd();
   endtask

   task automatic run_dump(input logic [4:0] first, input int count, input int stall0, input bit rnd);
      int n, s;
      logic [4:0] idx;
      n = (count > 32) ? 32 : count;
      chk("dp_cmd_ready", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1; cmd_op = 1'b0; cmd_first = first; cmd_count = 6'(count);
      out_ready = 1'b1;
      tick();
      chk("dp_acc_busy", 32'(busy), 32'd1);
      chk("dp_acc_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("dp_acc_valid", 32'(out_valid), 32'd0);
      chk("dp_acc_done", 32'(done), 32'(n == 0));
      if (n == 0) begin
         out_ready = 1'b0;
         finish_cmd();
         return;
      end
      idx = first;
      for (int k = 0; k < n; k++) begin
         noise();
         out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         tick();
         chk("dp_valid", 32'(out_valid), 32'd1);
         chk("dp_idx", 32'(out_idx), 32'(idx));
         chk("dp_data", out_data, ref_mem[idx]);
         chk("dp_we", 32'(rf_we), 32'd0);
         chk("dp_done_early", 32'(done), 32'd0);
         s = (k == 0) ? stall0 : (rnd ? int'($urandom_range(0, 3)) : 0);
         for (int j = 0; j < s; j++) begin
            noise();
            out_ready = 1'b0;
            tick();
            chk("dp_stall_valid", 32'(out_valid), 32'd1);
            chk("dp_stall_idx", 32'(out_idx), 32'(idx));
            chk("dp_stall_data", out_data, ref_mem[idx]);
         end
         noise();
         out_ready = 1'b1;
         tick();
         chk("dp_hs_valid", 32'(out_valid), 32'd0);
         chk("dp_hs_done", 32'(done), 32'(k == n - 1));
         idx = idx + 5'd1;
      end
      out_ready = 1'b0;
      finish_cmd();
   endtask

   initial begin
      logic [4:0] f;
      rst = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_first = '0; cmd_count = '0;
      out_ready = 1'b0; ld_valid = 1'b0; ld_data = '0;
      tick();
      tick();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_ld_ready", 32'(ld_ready), 32'd0);
      chk("rst_we", 32'(rf_we), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_out_idx", 32'(out_idx), 32'd0);
      chk("rst_raddr", 32'(rf_raddr), 32'd0);
      chk("rst_wr", 32'(rf_wr), 32'd0);
      chk("rst_wd", rf_wd, 32'd0);
      rst = 1'b0;
      tick();
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);

      // Back-to-back load, then read it straight back with out_ready held high.
      ld_pct = 100;
      ld_words.push_back(32'hDEADBEEF);
      ld_words.push_back(32'h12345678);
      run_load(5'd3, 2);
      run_dump(5'd3, 2, 0, 1'b0);

      // Wrapping range with a long stall on the first word; index 0 reads back as 0.
      run_load(5'd30, 4);
      run_dump(5'd30, 4, 5, 1'b0);

      // Writes to index 0 are swallowed.
      ld_words.push_back(32'hFFFFFFFF);
      run_load(5'd0, 1);
      run_dump(5'd0, 1, 0, 1'b0);

      // Zero-length and over-length commands.
      run_load(5'd7, 0);
      run_dump(5'd9, 0, 0, 1'b0);
      ld_pct = 70;
      run_load(5'($urandom()), 40);
      run_dump(5'($urandom()), 40, 2, 1'b1);

      // Reset while the third word of an 8-word load is being transferred.
      f = 5'($urandom_range(1, 24));
      cmd_valid = 1'b1; cmd_op = 1'b1; cmd_first = f; cmd_count = 6'd8;
      tick();
      cmd_valid = 1'b0;
      for (int k = 0; k < 2; k++) begin
         ld_valid = 1'b1; ld_data = $urandom();
         tick();
         chk("mr_we", 32'(rf_we), 32'd1);
         chk("mr_wr", 32'(rf_wr), 32'(f));
         ref_mem[f] = ld_data;
         f = f + 5'd1;
      end
      ld_data = $urandom();
      rst = 1'b1;
      tick();
      chk("mr_we_drop", 32'(rf_we), 32'd0);
      chk("mr_busy", 32'(busy), 32'd0);
      chk("mr_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("mr_done", 32'(done), 32'd0);
      chk("mr_ld_ready", 32'(ld_ready), 32'd0);
      chk("mr_raddr", 32'(rf_raddr), 32'd0);
      rst = 1'b0; ld_valid = 1'b0;
      tick();
      chk("mr_done_after", 32'(done), 32'd0);
      chk("mr_busy_after", 32'(busy), 32'd0);
      chk("mr_we_after", 32'(rf_we), 32'd0);

      // Randomized mix of commands against the reference contents.
      for (int i = 0; i < 10; i++) begin
         if ($urandom_range(0, 1) == 1)
            run_load(5'($urandom()), int'($urandom_range(0, 40)));
         else
            run_dump(5'($urandom()), int'($urandom_range(0, 40)), int'($urandom_range(0, 2)), 1'b1);
      end
      run_dump(5'd0, 32, 0, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/regfile_dbg.md
REGFILE_DBG -- requirements
Module: regfile_dbg

Interface
REQ-001 No parameters; the register file is fixed at 32 x 32-bit with 5-bit indices.
REQ-002 clk  in  1  clock; all state updates on the rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 cmd_valid  in  1  command request.
REQ-005 cmd_ready  out  1  high only in IDLE; a command is accepted on an edge where cmd_valid and cmd_ready are both high.
REQ-006 cmd_op  in  1  0 = dump (read registers out), 1 = load (write registers in).
REQ-007 cmd_first  in  5  first register index.
REQ-008 cmd_count  in  6  number of registers to transfer.
REQ-009 out_valid, out_ready  out/in  1  dump output stream handshake.
REQ-010 out_data, out_idx  out  32/5  dumped register value and its index.
REQ-011 ld_valid, ld_ready  in/out  1  load input stream handshake.
REQ-012 ld_data  in  32  load word.
REQ-013 rf_raddr  out  5  register-file read address; read data is sampled on the falling edge.
REQ-014 rf_rdata  in  32  register-file read data; valid at the first rising edge after rf_raddr changes.
REQ-015 rf_wE, rf_wR, rf_wD  out  1/5/32  register-file write port; the write commits on the rising edge.
REQ-016 busy  out  1  high in any state other than IDLE.
REQ-017 done  out  1  one-cycle pulse when a command completes.

Function
REQ-018 The FSM SHALL have the states IDLE, RD_CAP, RD_OUT, LOAD and DONE, and SHALL drive every output from registers.
REQ-019 On command accept, the block SHALL latch cmd_op, set idx = cmd_first, set rem = min(cmd_count, 32), and set rf_raddr = cmd_first.
REQ-020 If cmd_count is 0, the FSM SHALL go IDLE->DONE with no transfers.
REQ-021 Dump: IDLE->RD_CAP; at the RD_CAP edge it SHALL capture out_data = rf_rdata and out_idx = idx, set out_valid = 1, and go to RD_OUT.
REQ-022 In RD_OUT, out_valid, out_data and out_idx SHALL hold stable until out_ready is high.
REQ-023 On each out handshake the block SHALL clear out_valid, set idx = idx+1 mod 32, set rf_raddr = idx+1 mod 32, and decrement rem.
REQ-024 After a dump handshake: rem != 0 -> RD_CAP; rem = 0 -> DONE.
REQ-025 Dump timing: the first out_valid SHALL appear 2 cycles after the accept edge, with one bubble cycle between words, giving a maximum rate of 1 word per 2 cycles.
REQ-026 Load: in LOAD, ld_ready SHALL be high; on each ld handshake the block SHALL register rf_wE = 1, rf_wR = idx and rf_wD = ld_data for exactly the next cycle, then increment idx mod 32 and decrement rem.
REQ-027 Loads SHALL support back-to-back transfers every cycle, with rf_wE following each transfer by one cycle.
REQ-028 On a load transfer that sets rem to 0, the FSM SHALL go to DONE and ld_ready SHALL drop on the following cycle.
REQ-029 Index 0 on load: the word SHALL be consumed but rf_wE SHALL stay 0 for that slot.
REQ-030 Index 0 on dump: out_data SHALL be rf_rdata as returned, expected 0.
REQ-031 rf_wE SHALL be 0 in all cycles other than those following a load transfer.
REQ-032 DONE SHALL last one cycle with done = 1 and cmd_ready = 0, then go to IDLE.
REQ-033 The final load write SHALL be asserted in the DONE cycle.
REQ-034 Index wrap: 31 SHALL be followed by 0, for example first = 30 with count = 4 visits 30, 31, 0, 1.
REQ-035 cmd_valid outside IDLE SHALL be ignored and never queued.
REQ-036 ld_valid outside LOAD and out_ready outside RD_OUT SHALL have no effect.

Reset
REQ-037 When rst is high at an edge, the block SHALL go to IDLE and clear out_valid, ld_ready, rf_wE, done, busy, out_data, out_idx, rf_raddr, rf_wR, rf_wD, idx and rem to 0.
REQ-038 cmd_ready SHALL be 1 from the first cycle after reset.
REQ-039 Reset mid-operation SHALL abort the command, drop any pending write (rf_wE = 0 on the next cycle), and produce no done pulse.

Verification
REQ-040 Load first=3 count=2, ld_data 0xDEADBEEF then 0x12345678 on consecutive cycles -> rf_wE pulses on 2 consecutive cycles with wR 3, 4; done pulses in the second write cycle.
REQ-041 Dump first=3 count=2 after REQ-040, out_ready tied high -> out words (3, 0xDEADBEEF), (4, 0x12345678); first out_valid 2 cycles after accept; done 1 cycle after the last handshake.
REQ-042 Dump first=30 count=4 with out_ready low for 5 cycles on the first word -> out_data stable throughout the stall; indices 30, 31, 0, 1; index 0 yields 0.
REQ-043 Load first=0 count=1 with data 0xFFFFFFFF -> word consumed, no rf_wE, done pulses; a subsequent dump of index 0 returns 0.
REQ-044 cmd_count=0 -> done the cycle after accept, no traffic; cmd_count=40 -> exactly 32 transfers.
REQ-045 rst asserted during the third load word of a count=8 load -> next cycle rf_wE = 0, busy = 0, cmd_ready = 1, and no done pulse.
